adaptive_filter_stream_pair: RTL and testbench

- Sits directly upstream of the LMS/NLMS HLS core inside the adaptive-filter RFNoC block, between the NoC shell main/aux data outputs and the core's main_in/aux_in ports.
- Buffers the two independent sample streams and releases them to the core strictly as sample pairs.
- Forces packet boundaries on both outputs to follow the main stream.
- Counts and repairs tlast misalignment between the main and aux streams.

---
 rtl/adaptive_filter_stream_pair.sv | 251 +++++++++++++++++++++++++
 tb/tb_adaptive_filter_stream_pair.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_filter_stream_pair.sv
// adaptive_filter_stream_pair
//   Front end for the LMS/NLMS core. Buffers the main and aux sample streams
//   in two independent FIFOs and hands them to the core only as aligned pairs.
//   Packet boundaries on both outputs follow the main stream. A main/aux
//   tlast disagreement is counted and repaired: an early aux boundary is
//   ignored, and an early main boundary makes the block discard aux beats up
//   to and including the next aux tlast (DRAIN_AUX).
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   main_in_*, aux_in_*     AXI-Stream sinks (TDATA/TVALID/TREADY/TLAST)
//   main_out_*, aux_out_*   AXI-Stream sources towards the core
//   clear_count             synchronous clear of mismatch_count
//   mismatch_count          saturating count of tlast mismatches
//   draining                high while the FSM is in DRAIN_AUX
//
// Handshake semantics (all stream ports): a beat transfers on a rising edge
// where TVALID and TREADY are both high. TVALID never depends on TREADY, and
// once asserted the source holds TVALID and its payload until the transfer.

module adaptive_filter_stream_pair_fifo #(
    parameter int W  = 33,
    parameter int AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    input  logic         rd_en,
    output logic         not_empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          ready_q;
    logic          do_wr;
    logic          do_rd;

    // Ready comes from a register only; it is 0 while in reset and afterwards
    // reflects "not full" as computed for the count that is being stored.
    assign wr_ready  = ready_q;
    assign not_empty = (count != '0);
    assign rd_data   = mem[rd_ptr];
    assign do_wr     = wr_valid & ready_q;
    assign do_rd     = rd_en & not_empty;

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            ready_q <= (count_next != FULL_COUNT);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module adaptive_filter_stream_pair #(
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 5,
    parameter int CNT_W   = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] main_in_TDATA,
    input  logic              main_in_TVALID,
    output logic              main_in_TREADY,
    input  logic              main_in_TLAST,
    input  logic [DATA_W-1:0] aux_in_TDATA,
    input  logic              aux_in_TVALID,
    output logic              aux_in_TREADY,
    input  logic              aux_in_TLAST,
    output logic [DATA_W-1:0] main_out_TDATA,
    output logic              main_out_TVALID,
    input  logic              main_out_TREADY,
    output logic              main_out_TLAST,
    output logic [DATA_W-1:0] aux_out_TDATA,
    output logic              aux_out_TVALID,
    input  logic              aux_out_TREADY,
    output logic              aux_out_TLAST,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              draining
);
    typedef enum logic {
        ST_PAIR      = 1'b0,
        ST_DRAIN_AUX = 1'b1
    } state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    logic [DATA_W:0] main_head;
    logic [DATA_W:0] aux_head;
    logic            main_ne;
    logic            aux_ne;
    logic            main_pop;
    logic            aux_pop;

    adaptive_filter_stream_pair_fifo #(.W(DATA_W + 1), .AW(FIFO_AW)) u_main_fifo (
        .clk       (ap_clk),
        .rst_n     (rst_n_int),
        .wr_data   ({main_in_TLAST, main_in_TDATA}),
        .wr_valid  (main_in_TVALID),
        .wr_ready  (main_in_TREADY),
        .rd_data   (main_head),
        .rd_en     (main_pop),
        .not_empty (main_ne)
    );

    adaptive_filter_stream_pair_fifo #(.W(DATA_W + 1), .AW(FIFO_AW)) u_aux_fifo (
        .clk       (ap_clk),
        .rst_n     (rst_n_int),
        .wr_data   ({aux_in_TLAST, aux_in_TDATA}),
        .wr_valid  (aux_in_TVALID),
        .wr_ready  (aux_in_TREADY),
        .rd_data   (aux_head),
        .rd_en     (aux_pop),
        .not_empty (aux_ne)
    );

    // Pair register. Only the main tlast is kept: both outputs carry it, and
    // the aux tlast has already been consumed by the mismatch logic at load.
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] pair_main_data;
    logic [DATA_W-1:0] pair_aux_data;
    logic              pair_tlast;
    logic              pair_valid;
    logic              main_taken;
    logic              aux_taken;
    logic              main_hs;
    logic              aux_hs;
    logic              retire;
    logic              load;
    logic              mismatch_inc;
    logic [CNT_W-1:0]  cnt_q;

    assign main_out_TVALID = pair_valid & ~main_taken;
    assign aux_out_TVALID  = pair_valid & ~aux_taken;
    assign main_out_TDATA  = pair_main_data;
    assign aux_out_TDATA   = pair_aux_data;
    assign main_out_TLAST  = pair_tlast;
    assign aux_out_TLAST   = pair_tlast;
    assign main_hs         = main_out_TVALID & main_out_TREADY;
    assign aux_hs          = aux_out_TVALID & aux_out_TREADY;
    // Retire once each side has either already transferred or transfers now.
    assign retire          = pair_valid & (main_taken | main_hs) & (aux_taken | aux_hs);
    assign draining        = (state_q == ST_DRAIN_AUX);
    assign mismatch_count  = cnt_q;

    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) state_q <= ST_PAIR;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        main_pop     = 1'b0;
        aux_pop      = 1'b0;
        mismatch_inc = 1'b0;
        case (state_q)
            ST_PAIR: begin
                if (main_ne && aux_ne && (!pair_valid || retire)) begin
                    load     = 1'b1;
                    main_pop = 1'b1;
                    aux_pop  = 1'b1;
                    if (main_head[DATA_W] != aux_head[DATA_W]) mismatch_inc = 1'b1;
                    // Main packet ended before aux: drop the rest of the aux packet.
                    if (main_head[DATA_W] && !aux_head[DATA_W]) state_d = ST_DRAIN_AUX;
                end
            end
            ST_DRAIN_AUX: begin
                if (aux_ne) begin
                    aux_pop = 1'b1;
                    if (aux_head[DATA_W]) state_d = ST_PAIR;
                end
            end
            default: state_d = ST_PAIR;
        endcase
    end

    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pair_valid     <= 1'b0;
            main_taken     <= 1'b0;
            aux_taken      <= 1'b0;
            pair_main_data <= '0;
            pair_aux_data  <= '0;
            pair_tlast     <= 1'b0;
        end else if (load) begin
            pair_valid     <= 1'b1;
            main_taken     <= 1'b0;
            aux_taken      <= 1'b0;
            pair_main_data <= main_head[DATA_W-1:0];
            pair_aux_data  <= aux_head[DATA_W-1:0];
            pair_tlast     <= main_head[DATA_W];
        end else if (retire) begin
            pair_valid <= 1'b0;
            main_taken <= 1'b0;
            aux_taken  <= 1'b0;
        end else begin
            if (main_hs) main_taken <= 1'b1;
            if (aux_hs)  aux_taken  <= 1'b1;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cnt_q <= '0;
        end else if (clear_count) begin
            cnt_q <= '0;
        end else if (mismatch_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_adaptive_filter_stream_pair.sv
module tb_adaptive_filter_stream_pair;
  localparam int DATA_W  = 32;
  localparam int FIFO_AW = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 400;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [DATA_W-1:0] main_in_TDATA = '0;
  logic              main_in_TVALID = 1'b0;
  logic              main_in_TREADY;
  logic              main_in_TLAST = 1'b0;
  logic [DATA_W-1:0] aux_in_TDATA = '0;
  logic              aux_in_TVALID = 1'b0;
  logic              aux_in_TREADY;
  logic              aux_in_TLAST = 1'b0;
  logic [DATA_W-1:0] main_out_TDATA;
  logic              main_out_TVALID;
  logic              main_out_TREADY = 1'b1;
  logic              main_out_TLAST;
  logic [DATA_W-1:0] aux_out_TDATA;
  logic              aux_out_TVALID;
  logic              aux_out_TREADY = 1'b1;
  logic              aux_out_TLAST;
  logic              clear_count = 1'b0;
  logic [CNT_W-1:0]  mismatch_count;
  logic              draining;

  adaptive_filter_stream_pair #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .CNT_W(CNT_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .main_in_TDATA   (main_in_TDATA),
    .main_in_TVALID  (main_in_TVALID),
    .main_in_TREADY  (main_in_TREADY),
    .main_in_TLAST   (main_in_TLAST),
    .aux_in_TDATA    (aux_in_TDATA),
    .aux_in_TVALID   (aux_in_TVALID),
    .aux_in_TREADY   (aux_in_TREADY),
    .aux_in_TLAST    (aux_in_TLAST),
    .main_out_TDATA  (main_out_TDATA),
    .main_out_TVALID (main_out_TVALID),
    .main_out_TREADY (main_out_TREADY),
    .main_out_TLAST  (main_out_TLAST),
    .aux_out_TDATA   (aux_out_TDATA),
    .aux_out_TVALID  (aux_out_TVALID),
    .aux_out_TREADY  (aux_out_TREADY),
    .aux_out_TLAST   (aux_out_TLAST),
    .clear_count     (clear_count),
    .mismatch_count  (mismatch_count),
    .draining        (draining)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int main_acc = 0;
  int drain_cycles = 0;
  logic [DATA_W:0] main_src[$];
  logic [DATA_W:0] aux_src[$];
  logic [DATA_W:0] exp_main_q[$];
  logic [DATA_W:0] exp_aux_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic src_main(input logic [DATA_W-1:0] d, input logic tl);
    main_src.push_back({tl, d});
  endtask

  task automatic src_aux(input logic [DATA_W-1:0] d, input logic tl);
    aux_src.push_back({tl, d});
  endtask

  task automatic exp_pair(input logic [DATA_W-1:0] md, input logic [DATA_W-1:0] ad, input logic tl);
    exp_main_q.push_back({tl, md});
    exp_aux_q.push_back({tl, ad});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_main();
    logic [DATA_W:0] b;
    int w;
    while (main_src.size() > 0) begin
      b = main_src.pop_front();
      main_in_TVALID = 1'b1;
      main_in_TDATA  = b[DATA_W-1:0];
      main_in_TLAST  = b[DATA_W];
      w = 0;
      while (!main_in_TREADY && w < TIMEOUT) begin
        tick();
        w++;
      end
      if (!main_in_TREADY) begin
        chk("main_in_accept_timeout", main_in_TREADY, 1);
        main_src.delete();
      end else begin
        tick();
        main_acc++;
      end
    end
    main_in_TVALID = 1'b0;
    main_in_TLAST  = 1'b0;
  endtask

  task automatic drive_aux();
    logic [DATA_W:0] b;
    int w;
    while (aux_src.size() > 0) begin
      b = aux_src.pop_front();
      aux_in_TVALID = 1'b1;
      aux_in_TDATA  = b[DATA_W-1:0];
      aux_in_TLAST  = b[DATA_W];
      w = 0;
      while (!aux_in_TREADY && w < TIMEOUT) begin
        tick();
        w++;
      end
      if (!aux_in_TREADY) begin
        chk("aux_in_accept_timeout", aux_in_TREADY, 1);
        aux_src.delete();
      end else begin
        tick();
      end
    end
    aux_in_TVALID = 1'b0;
    aux_in_TLAST  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while ((exp_main_q.size() != 0 || exp_aux_q.size() != 0) && w < TIMEOUT) begin
      tick();
      w++;
    end
    chk(tag, exp_main_q.size() + exp_aux_q.size(), 0);
    repeat (2) tick();
  endtask

  // ---------------- output monitor ----------------
  always @(negedge ap_clk) begin
    logic [DATA_W:0] e;
    if (draining) drain_cycles++;
    if (main_out_TVALID && main_out_TREADY) begin
      e = (exp_main_q.size() > 0) ? exp_main_q.pop_front() : 'x;
      chk("main_out_beat", {main_out_TLAST, main_out_TDATA}, e);
    end
    if (aux_out_TVALID && aux_out_TREADY) begin
      e = (exp_aux_q.size() > 0) ? exp_aux_q.pop_front() : 'x;
      chk("aux_out_beat", {aux_out_TLAST, aux_out_TDATA}, e);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int acc_base;
    int drain_base;

    // Reset state
    repeat (3) tick();
    chk("rst_main_in_ready", main_in_TREADY, 0);
    chk("rst_aux_in_ready", aux_in_TREADY, 0);
    chk("rst_main_out_valid", main_out_TVALID, 0);
    chk("rst_aux_out_valid", aux_out_TVALID, 0);
    chk("rst_count", mismatch_count, 0);
    chk("rst_draining", draining, 0);
    ap_rst_n = 1'b1;
    w = 0;
    while (!(main_in_TREADY && aux_in_TREADY) && w < 20) begin
      tick();
      w++;
    end
    chk("rst_release_ready", {main_in_TREADY, aux_in_TREADY}, 2'b11);

    // Test 1: aligned 8-beat packets, latency and back-to-back throughput
    for (int i = 1; i <= 8; i++) begin
      src_main(i, i == 8);
      src_aux(32'h10 + i, i == 8);
      exp_pair(i, 32'h10 + i, i == 8);
    end
    fork
      drive_main();
      drive_aux();
      begin
        int pw;
        int run;
        #1;
        pw = 0;
        while (!(main_in_TVALID && main_in_TREADY && aux_in_TVALID && aux_in_TREADY) && pw < TIMEOUT) begin
          @(posedge ap_clk); #2;
          pw++;
        end
        @(posedge ap_clk); #2;
        chk("t1_valid_after_accept_edge", main_out_TVALID, 0);
        @(posedge ap_clk); #2;
        chk("t1_main_valid_next_edge", main_out_TVALID, 1);
        chk("t1_aux_valid_next_edge", aux_out_TVALID, 1);
        run = 0;
        for (int k = 0; k < 8; k++) begin
          if (main_out_TVALID && aux_out_TVALID) run++;
          @(posedge ap_clk); #2;
        end
        chk("t1_consecutive_pairs", run, 8);
      end
    join
    wait_drain("t1_drain");
    chk("t1_count", mismatch_count, 0);

    // Test 2: aux arrives late, aux output stalled for 3 cycles
    aux_out_TREADY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      src_main(32'h20 + i, i == 4);
      src_aux(32'h30 + i, i == 4);
      exp_pair(32'h20 + i, 32'h30 + i, i == 4);
    end
    fork
      drive_main();
      begin
        repeat (10) tick();
        drive_aux();
      end
      begin
        int pw;
        #1;
        pw = 0;
        while (!main_out_TVALID && pw < TIMEOUT) begin
          @(posedge ap_clk); #2;
          pw++;
        end
        chk("t2_first_valid", main_out_TVALID, 1);
        for (int k = 1; k <= 3; k++) begin
          @(posedge ap_clk); #2;
          chk("t2_main_valid_held_low", main_out_TVALID, 0);
          chk("t2_aux_valid_held", aux_out_TVALID, 1);
        end
        aux_out_TREADY = 1'b1;
        @(posedge ap_clk); #2;
        chk("t2_next_pair_valid", main_out_TVALID, 1);
        chk("t2_next_pair_data", main_out_TDATA, 32'h22);
      end
    join
    wait_drain("t2_drain");

    // Test 3: main packet of 4, aux packet of 6
    drain_base = drain_cycles;
    for (int i = 1; i <= 8; i++) src_main(32'h40 + i, (i == 4) || (i == 8));
    for (int i = 1; i <= 10; i++) src_aux(32'h50 + i, (i == 6) || (i == 10));
    for (int i = 1; i <= 4; i++) exp_pair(32'h40 + i, 32'h50 + i, i == 4);
    for (int i = 5; i <= 8; i++) exp_pair(32'h40 + i, 32'h50 + i + 2, i == 8);
    fork
      drive_main();
      drive_aux();
    join
    wait_drain("t3_drain");
    chk("t3_draining_cycles_ge2", (drain_cycles - drain_base) >= 2, 1);
    chk("t3_count", mismatch_count, 1);
    chk("t3_back_in_pair", draining, 0);

    // Test 4: early aux boundary is ignored
    drain_base = drain_cycles;
    for (int i = 1; i <= 4; i++) begin
      src_main(32'h60 + i, i == 4);
      src_aux(32'h70 + i, (i == 2) || (i == 4));
      exp_pair(32'h60 + i, 32'h70 + i, i == 4);
    end
    fork
      drive_main();
      drive_aux();
    join
    wait_drain("t4_drain");
    chk("t4_no_drain", drain_cycles - drain_base, 0);
    chk("t4_count", mismatch_count, 2);

    // Test 5: 40 main beats with aux absent, then aux starts
    acc_base = main_acc;
    for (int i = 1; i <= 40; i++) begin
      src_main(32'h100 + i, i == 40);
      src_aux(32'h200 + i, i == 40);
      exp_pair(32'h100 + i, 32'h200 + i, i == 40);
    end
    fork
      drive_main();
      begin
        repeat (62) tick();
        drive_aux();
      end
      begin
        int pw;
        logic prev_rdy;
        #1;
        repeat (60) begin
          @(posedge ap_clk); #2;
        end
        chk("t5_accepts_before_full", main_acc - acc_base, 32);
        chk("t5_ready_low_when_full", main_in_TREADY, 0);
        chk("t5_no_output_without_aux", main_out_TVALID, 0);
        pw = 0;
        prev_rdy = main_in_TREADY;
        while (!main_out_TVALID && pw < TIMEOUT) begin
          prev_rdy = main_in_TREADY;
          @(posedge ap_clk); #2;
          pw++;
        end
        chk("t5_ready_before_first_pair", prev_rdy, 0);
        chk("t5_ready_with_first_pair", main_in_TREADY, 1);
      end
    join
    wait_drain("t5_drain");
    chk("t5_count", mismatch_count, 2);

    // Test 6: saturation, then clear coincident with a mismatch
    for (int i = 1; i <= 260; i++) begin
      src_main(32'h1000 + i, 1'b0);
      src_aux(32'h2000 + i, 1'b1);
      exp_pair(32'h1000 + i, 32'h2000 + i, 1'b0);
    end
    fork
      drive_main();
      drive_aux();
    join
    wait_drain("t6_drain");
    chk("t6_saturated", mismatch_count, 8'hFF);
    exp_pair(32'h3001, 32'h4001, 1'b0);
    main_in_TDATA = 32'h3001; main_in_TLAST = 1'b0; main_in_TVALID = 1'b1;
    aux_in_TDATA  = 32'h4001; aux_in_TLAST  = 1'b1; aux_in_TVALID  = 1'b1;
    chk("t6_ready_before_clear", {main_in_TREADY, aux_in_TREADY}, 2'b11);
    tick();
    main_in_TVALID = 1'b0; aux_in_TVALID = 1'b0; aux_in_TLAST = 1'b0;
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("t6_clear_wins", mismatch_count, 0);
    wait_drain("t6_clear_drain");
    chk("t6_count_stays_clear", mismatch_count, 0);

    // Test 7: reset in the middle of a packet
    main_out_TREADY = 1'b0;
    aux_out_TREADY  = 1'b0;
    for (int i = 1; i <= 6; i++) src_main(32'h500 + i, 1'b0);
    for (int i = 1; i <= 3; i++) src_aux(32'h600 + i, 1'b0);
    fork
      drive_main();
      drive_aux();
    join
    repeat (3) tick();
    chk("t7_pair_pending", main_out_TVALID, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("t7_rst_main_valid", main_out_TVALID, 0);
    chk("t7_rst_aux_valid", aux_out_TVALID, 0);
    chk("t7_rst_in_ready", {main_in_TREADY, aux_in_TREADY}, 2'b00);
    chk("t7_rst_draining", draining, 0);
    repeat (2) tick();
    ap_rst_n = 1'b1;
    main_out_TREADY = 1'b1;
    aux_out_TREADY  = 1'b1;
    repeat (10) tick();
    chk("t7_empty_after_release", {main_out_TVALID, aux_out_TVALID}, 2'b00);
    chk("t7_ready_after_release", {main_in_TREADY, aux_in_TREADY}, 2'b11);
    for (int i = 1; i <= 2; i++) begin
      src_main(32'h700 + i, i == 2);
      src_aux(32'h800 + i, i == 2);
      exp_pair(32'h700 + i, 32'h800 + i, i == 2);
    end
    fork
      drive_main();
      drive_aux();
    join
    wait_drain("t7_drain");
    chk("t7_count", mismatch_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
